// File: rtl/wall_map.sv
// wall_map - wall-grid store for the tank game field.
//
// Holds one wall bit per 10x10-pixel grid cell: MAP_W columns by MAP_H rows.
// The status bar is not part of the map. The store has two registered read
// ports and one buffered write path:
//   - display port : i_request_x/i_request_y -> o_is_wall  (1-cycle latency)
//   - query port   : i_qry_x/i_qry_y         -> o_qry_wall (1-cycle latency)
//   - write path   : i_wr_valid/o_wr_ready with i_wr_x/i_wr_y/i_wr_data.
//     Writes go into a small FIFO. They are committed only while i_buzy is
//     low, so the display never shows a half-updated frame.
// Control:
//   - i_clear : restarts the border-only initialization (new round).
//   - o_ready : high once initialization is complete (state RUN).
// Clock clk, asynchronous active-low reset rst_n.

module wall_map #(
  parameter int MAP_W      = 64,
  parameter int MAP_H      = 44,
  parameter int FIFO_DEPTH = 4    // must be a power of two (pointers wrap naturally)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_buzy,
  input  logic [5:0] i_request_x,
  input  logic [5:0] i_request_y,
  output logic       o_is_wall,
  input  logic [5:0] i_qry_x,
  input  logic [5:0] i_qry_y,
  output logic       o_qry_wall,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [5:0] i_wr_x,
  input  logic [5:0] i_wr_y,
  input  logic       i_wr_data,
  input  logic       i_clear,
  output logic       o_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state_reg;
  logic [5:0]    r_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;

  // Map storage and write FIFO payload. Neither is reset: INIT defines every
  // map bit, and FIFO slots are only read after being written.
  logic [MAP_W-1:0] map_mem [MAP_H];
  logic [5:0]       fx_mem  [FIFO_DEPTH];
  logic [5:0]       fy_mem  [FIFO_DEPTH];
  logic             fd_mem  [FIFO_DEPTH];

  logic             in_run;
  logic             push;
  logic             pop;
  logic [5:0]       pop_x;
  logic [5:0]       pop_y;
  logic             pop_d;
  logic [MAP_W-1:0] init_row;

  assign in_run     = (state_reg == S_RUN);
  assign o_ready    = in_run;
  // No bypass while full: a pop in the same cycle does not free a slot early.
  assign o_wr_ready = in_run && (count_reg < CW'(FIFO_DEPTH));
  assign push       = i_wr_valid && o_wr_ready;
  // A clear discards pending entries, so nothing is committed in that cycle.
  // i_buzy is used combinationally; the display stage already registers it.
  assign pop        = in_run && !i_buzy && (count_reg != '0) && !i_clear;

  assign pop_x = fx_mem[rd_ptr_reg];
  assign pop_y = fy_mem[rd_ptr_reg];
  assign pop_d = fd_mem[rd_ptr_reg];

  // Border pattern: top and bottom rows solid, other rows only the side walls.
  always_comb begin
    init_row = '0;
    if (r_reg == 6'd0 || r_reg == 6'(MAP_H - 1)) begin
      init_row = '1;
    end else begin
      init_row[0]       = 1'b1;
      init_row[MAP_W-1] = 1'b1;
    end
  end

  // Control: FSM, row counter and FIFO pointers/count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_INIT;
      r_reg      <= '0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      case (state_reg)
        S_INIT: begin
          if (i_clear) begin
            r_reg <= '0;
          end else if (r_reg == 6'(MAP_H - 1)) begin
            r_reg     <= '0;
            state_reg <= S_RUN;
          end else begin
            r_reg <= r_reg + 6'd1;
          end
        end
        default: begin
          if (i_clear) begin
            state_reg  <= S_INIT;
            r_reg      <= '0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
          end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
              2'b10:   count_reg <= count_reg + CW'(1);
              2'b01:   count_reg <= count_reg - CW'(1);
              default: count_reg <= count_reg;
            endcase
          end
        end
      endcase
    end
  end

  // FIFO payload write.
  always_ff @(posedge clk) begin
    if (push) begin
      fx_mem[wr_ptr_reg] <= i_wr_x;
      fy_mem[wr_ptr_reg] <= i_wr_y;
      fd_mem[wr_ptr_reg] <= i_wr_data;
    end
  end

  // Map write: a full row per cycle during INIT, one committed cell in RUN.
  // Entries with y outside the field are popped with no storage effect.
  always_ff @(posedge clk) begin
    if (state_reg == S_INIT) begin
      map_mem[r_reg] <= init_row;
    end else if (pop && (pop_y < 6'(MAP_H))) begin
      map_mem[pop_y][pop_x] <= pop_d;
    end
  end

  // Read ports sample the map before any commit on the same edge. During
  // INIT the display sees an empty field while tanks see solid walls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_is_wall  <= 1'b0;
      o_qry_wall <= 1'b1;
    end else if (!in_run) begin
      o_is_wall  <= 1'b0;
      o_qry_wall <= 1'b1;
    end else begin
      o_is_wall  <= (i_request_y >= 6'(MAP_H)) ? 1'b1 : map_mem[i_request_y][i_request_x];
      o_qry_wall <= (i_qry_y     >= 6'(MAP_H)) ? 1'b1 : map_mem[i_qry_y][i_qry_x];
    end
  end

endmodule
